// File: rtl/vision_pkg.sv
// Shared types and helpers for the corner-score vision pipeline.
package vision_pkg;
  localparam int SCORE_BITS = 8;
  typedef logic signed [SCORE_BITS-1:0] score_t;
  typedef score_t [2:0][2:0] window3_t;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/score_window_generator_line_buffer.sv
// One-line sample delay; contents are unreset so it maps onto RAM.
module line_buffer
  import vision_pkg::*;
#(
  parameter int DEPTH     = 640,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [DATA_BITS-1:0] din_i,
  output logic [DATA_BITS-1:0] dout_o
);
  localparam int PW = coord_w(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        ptr_q;

  // Read-before-write: the slot being overwritten is the sample from DEPTH shifts ago.
  assign dout_o = mem[ptr_q];

  always_ff @(posedge clk) begin
    if (en_i) mem[ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr_q <= '0;
    else if (en_i) ptr_q <= (ptr_q == PLAST) ? '0 : ptr_q + 1'b1;
  end
endmodule

// File: rtl/score_window_generator.sv
// Raster-order score stream to registered sliding HxW windows with centre coordinates.
module score_window_generator
  import vision_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   in_valid,
  input  logic                                                   in_sof,
  input  logic [DATA_BITS-1:0]                                   in_data,
  output logic                                                   out_valid,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][DATA_BITS-1:0] out_window,
  output logic [coord_w(IMAGE_WIDTH)-1:0]                        out_x,
  output logic [coord_w(IMAGE_HEIGHT)-1:0]                       out_y,
  output logic                                                   frame_done
);
  localparam int H  = WINDOW_HEIGHT;
  localparam int W  = WINDOW_WIDTH;
  localparam int XW = coord_w(IMAGE_WIDTH);
  localparam int YW = coord_w(IMAGE_HEIGHT);
  localparam logic [XW-1:0] XLAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] YLAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] XMIN  = XW'(W - 1);
  localparam logic [YW-1:0] YMIN  = YW'(H - 1);
  localparam logic [XW-1:0] XOFF  = XW'((W - 1) / 2);
  localparam logic [YW-1:0] YOFF  = YW'((H - 1) / 2);

  typedef logic [H-1:0][W-1:0][DATA_BITS-1:0] win_t;

  state_e               state_q;
  logic [XW-1:0]        x_q, cur_x;
  logic [YW-1:0]        y_q, cur_y;
  win_t                 win_q, win_d, out_window_q;
  logic [XW-1:0]        out_x_q;
  logic [YW-1:0]        out_y_q;
  logic                 out_valid_q, frame_done_q;
  logic                 accept, emit, last;
  logic [H-1:0][DATA_BITS-1:0] col;
  logic [H-2:0][DATA_BITS-1:0] lb_out;

  assign accept = in_valid & (in_sof | (state_q == ACTIVE));
  assign cur_x  = in_sof ? '0 : x_q;
  assign cur_y  = in_sof ? '0 : y_q;
  assign emit   = accept && (cur_x >= XMIN) && (cur_y >= YMIN);
  assign last   = accept && (cur_x == XLAST) && (cur_y == YLAST);

  // Row H-1 is the live sample; each line buffer down the chain is one row older.
  assign col[H-1] = in_data;
  for (genvar g = 0; g < H - 1; g++) begin : g_lb
    if (g == 0) begin : g_first
      line_buffer #(.DEPTH(IMAGE_WIDTH), .DATA_BITS(DATA_BITS)) u_lb (
        .clk(clk), .rst(rst), .en_i(accept), .din_i(in_data), .dout_o(lb_out[g]));
    end else begin : g_next
      line_buffer #(.DEPTH(IMAGE_WIDTH), .DATA_BITS(DATA_BITS)) u_lb (
        .clk(clk), .rst(rst), .en_i(accept), .din_i(lb_out[g-1]), .dout_o(lb_out[g]));
    end
    assign col[H-2-g] = lb_out[g];
  end

  // Columns shift left; the window is only published once x >= W-1, so every
  // column it holds then belongs to the current line.
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][W-1] = col[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      win_q        <= '0;
      out_window_q <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= last;
      if (accept) begin
        win_q <= win_d;
        if (emit) begin
          out_window_q <= win_d;
          out_x_q      <= cur_x - XOFF;
          out_y_q      <= cur_y - YOFF;
        end
        if (last) begin
          state_q <= IDLE;
          x_q     <= '0;
          y_q     <= '0;
        end else begin
          state_q <= ACTIVE;
          if (cur_x == XLAST) begin
            x_q <= '0;
            y_q <= cur_y + 1'b1;
          end else begin
            x_q <= cur_x + 1'b1;
            y_q <= cur_y;
          end
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_window = out_window_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
endmodule

// File: tb/tb_score_window_generator.sv
// Directed scoreboard bench for score_window_generator on a 4x4 image with 3x3 windows.
module tb_score_window_generator;
  localparam int IW = 4, IH = 4, W = 3, H = 3, DB = 8;

  typedef logic [H-1:0][W-1:0][DB-1:0] win_t;
  typedef struct packed {
    win_t       win;
    logic [1:0] x;
    logic [1:0] y;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_sof;
  logic [DB-1:0] in_data;
  logic          out_valid, frame_done;
  win_t          out_window;
  logic [1:0]    out_x, out_y;

  score_window_generator #(
    .DATA_BITS(DB), .WINDOW_WIDTH(W), .WINDOW_HEIGHT(H),
    .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_window(out_window), .out_x(out_x), .out_y(out_y),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  exp_t          sb[$];
  int            n_assert = 0, n_fail = 0;
  bit            m_act = 0;
  int            mx = 0, my = 0;
  logic [DB-1:0] img [IH][IW];
  bit            exp_v, exp_fd;
  exp_t          last_exp = '0;
  win_t          first_win, ref_win;
  int            win_cnt, fd_cnt, lm_cnt;
  logic [1:0]    lm_x, lm_y;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // NonmaxSuppression with THRESHOLD=0: centre above threshold and strictly above all neighbours.
  function automatic bit is_local_max(input win_t w);
    bit m = ($signed(w[1][1]) > 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (!(r == 1 && c == 1) && !($signed(w[1][1]) > $signed(w[r][c]))) m = 0;
    return m;
  endfunction

  task automatic step(input bit v, input bit s, input logic [DB-1:0] d);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_sof = s; in_data = d;
    exp_v = 0; exp_fd = 0;
    if (v) begin
      if (s) begin m_act = 1; mx = 0; my = 0; end
      if (m_act) begin
        img[my][mx] = d;
        if (mx >= W - 1 && my >= H - 1) begin
          for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) e.win[r][c] = img[my-H+1+r][mx-W+1+c];
          e.x = 2'(mx - 1);
          e.y = 2'(my - 1);
          sb.push_back(e);
          exp_v = 1;
        end
        if (mx == IW - 1 && my == IH - 1) begin
          m_act = 0; exp_fd = 1; mx = 0; my = 0;
        end else if (mx == IW - 1) begin
          mx = 0; my++;
        end else mx++;
      end
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, exp_v);
    chk("frame_done", frame_done, exp_fd);
    if (frame_done) fd_cnt++;
    if (out_valid) begin
      chk("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("window", out_window, e.win);
        chk("out_x", out_x, e.x);
        chk("out_y", out_y, e.y);
        if (win_cnt == 0) first_win = out_window;
        last_exp = e;
        win_cnt++;
        if (is_local_max(out_window)) begin lm_cnt++; lm_x = out_x; lm_y = out_y; end
      end
    end else begin
      chk("window_hold", out_window, last_exp.win);
    end
  endtask

  task automatic frame(input bit gaps, input bit spot);
    for (int y = 0; y < IH; y++)
      for (int x = 0; x < IW; x++) begin
        if (gaps) repeat ($urandom_range(0, 2)) step(0, 1'($urandom_range(0, 1)), 8'hAA);
        step(1, (x == 0 && y == 0), spot ? ((x == 2 && y == 1) ? 8'd3 : 8'd0) : 8'(4 * y + x));
      end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sof = 0; in_data = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_window", out_window, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    @(negedge clk); @(negedge clk); rst = 0;

    // Sample before any sof is discarded
    step(1, 0, 8'h55);

    // Clean frame
    win_cnt = 0; fd_cnt = 0;
    frame(0, 0);
    ref_win = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    chk("first_window", first_win, ref_win);
    chk("t1_windows", win_cnt, 4);
    chk("t1_frame_done", fd_cnt, 1);

    // Same frame with random gaps
    win_cnt = 0; fd_cnt = 0;
    frame(1, 0);
    chk("t2_windows", win_cnt, 4);
    chk("t2_frame_done", fd_cnt, 1);

    // Mid-frame sof on the 7th sample
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 6; i++) step(1, (i == 0), 8'(i + 100));
    frame(0, 0);
    chk("t3_windows", win_cnt, 4);
    chk("t3_frame_done", fd_cnt, 1);

    // Trailing samples without sof
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 3; i++) step(1, 0, 8'(i + 50));
    chk("t4_windows", win_cnt, 0);
    chk("t4_frame_done", fd_cnt, 0);

    // Async reset mid-frame after pixel 9
    for (int i = 0; i < 10; i++) step(1, (i == 0), 8'(i));
    @(negedge clk); #2;
    rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_done", frame_done, 0);
    chk("midrst_window", out_window, 0);
    chk("midrst_out_x", out_x, 0);
    chk("midrst_out_y", out_y, 0);
    m_act = 0; mx = 0; my = 0; sb.delete(); last_exp = '0;
    @(negedge clk); rst = 0;
    step(1, 0, 8'h77);
    win_cnt = 0; fd_cnt = 0;
    frame(0, 0);
    chk("t5_first_window", first_win, ref_win);
    chk("t5_windows", win_cnt, 4);
    chk("t5_frame_done", fd_cnt, 1);

    // Single-peak frame feeding a local-max check
    win_cnt = 0; lm_cnt = 0;
    frame(0, 1);
    chk("t6_local_max_count", lm_cnt, 1);
    chk("t6_local_max_x", lm_x, 2);
    chk("t6_local_max_y", lm_y, 1);

    step(0, 0, 8'h00);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
